dmem_wb_arbiter: RTL



---
 rtl/dmem_wb_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/dmem_wb_arbiter.sv
// Data-memory arbiter (load/store round-robin) plus RF write-port sharing between
// load return data (always wins) and ALU writeback (back-pressured one cycle).
module dmem_wb_arbiter #(
    parameter int DMEM_DEPTH      = 1024,
    parameter int DMEM_ADDR_WIDTH = $clog2(DMEM_DEPTH),
    parameter int PRF_ADDR_WIDTH  = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [31:0]                ld_addr,
    input  logic [PRF_ADDR_WIDTH-1:0]  ld_rd,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [31:0]                st_addr,
    input  logic [31:0]                st_data,
    input  logic                       alu_wb_valid,
    output logic                       alu_wb_ready,
    input  logic [PRF_ADDR_WIDTH-1:0]  alu_wb_addr,
    input  logic [31:0]                alu_wb_data,
    output logic                       dmem_en,
    output logic                       dmem_we,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
    output logic [31:0]                dmem_din,
    input  logic [31:0]                dmem_dout,
    output logic                       rf_wr_en,
    output logic [PRF_ADDR_WIDTH-1:0]  rf_wr_addr,
    output logic [31:0]                rf_wr_data,
    output logic                       err_addr
);

    function automatic logic addr_oor(input logic [31:0] a);
        return |a[31:DMEM_ADDR_WIDTH+2];
    endfunction

    function automatic logic addr_misaligned(input logic [31:0] a);
        return |a[1:0];
    endfunction

    logic                      rr_ptr;      // 0: load preferred, 1: store preferred
    logic                      ld_pend;
    logic                      ld_oor_p1;
    logic [PRF_ADDR_WIDTH-1:0] ld_rd_p1;
    logic                      err_p1;

    logic        grant_ld;
    logic        grant_st;
    logic        access;
    logic        sel_oor;
    logic        sel_mis;
    logic [31:0] sel_addr;

    // Stage 0: combinational grant and RAM access
    always_comb begin
        grant_ld  = rst && ld_valid && (!st_valid || !rr_ptr);
        grant_st  = rst && st_valid && !grant_ld;
        access    = grant_ld || grant_st;
        sel_addr  = grant_ld ? ld_addr : st_addr;
        sel_oor   = addr_oor(sel_addr);
        sel_mis   = addr_misaligned(sel_addr);

        ld_ready  = grant_ld;
        st_ready  = grant_st;
        dmem_en   = access && !sel_oor;
        dmem_we   = dmem_en && grant_st;
        dmem_addr = dmem_en ? sel_addr[DMEM_ADDR_WIDTH+1:2] : '0;
        dmem_din  = dmem_we ? st_data : '0;
    end

    // Stage 1: load return tracking, error pulse and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst) begin
            ld_pend   <= 1'b0;
            ld_oor_p1 <= 1'b0;
            err_p1    <= 1'b0;
            rr_ptr    <= 1'b0;
        end else begin
            ld_pend <= grant_ld;
            if (grant_ld)
                ld_oor_p1 <= sel_oor;
            err_p1 <= access && (sel_oor || sel_mis);
            // Only contended grants move the pointer
            if (ld_valid && st_valid)
                rr_ptr <= ~rr_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (grant_ld)
            ld_rd_p1 <= ld_rd;
    end

    // RF write port: pending load return beats ALU writeback
    always_comb begin
        rf_wr_en     = 1'b0;
        rf_wr_addr   = '0;
        rf_wr_data   = '0;
        alu_wb_ready = rst && !ld_pend;
        if (rst) begin
            if (ld_pend) begin
                rf_wr_en   = 1'b1;
                rf_wr_addr = ld_rd_p1;
                rf_wr_data = ld_oor_p1 ? 32'd0 : dmem_dout;
            end else if (alu_wb_valid) begin
                rf_wr_en   = 1'b1;
                rf_wr_addr = alu_wb_addr;
                rf_wr_data = alu_wb_data;
            end
        end
    end

    assign err_addr = rst && err_p1;

endmodule
